// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle data-memory responder for the core's loads and stores.
// Handles byte-lane steering, write strobes, load extension, misalignment faults and bus timeout.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lsu_valid,
  input  logic        lsu_we,
  input  logic [1:0]  Store,
  input  logic [2:0]  Load,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic [31:0] lsu_rdata,
  output logic        lsu_done,
  output logic        lsu_fault,
  output logic        lsu_busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_RESP  = 3'd2,
    S_DONE  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  localparam logic [8:0] TO_LIMIT = 9'(TIMEOUT_CYCLES);

  function automatic logic access_ok(input logic we, input logic [1:0] st,
                                     input logic [2:0] ld, input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    if (we) begin
      case (st)
        2'b00:   ok = 1'b1;
        2'b01:   ok = ~off[0];
        2'b10:   ok = (off == 2'b00);
        default: ok = 1'b0;
      endcase
    end else begin
      case (ld)
        3'b000, 3'b011: ok = 1'b1;
        3'b001, 3'b100: ok = ~off[0];
        3'b010:         ok = (off == 2'b00);
        default:        ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  function automatic logic [31:0] store_wdata(input logic [1:0] st, input logic [31:0] wd);
    logic [31:0] r;
    case (st)
      2'b00:   r = {4{wd[7:0]}};
      2'b01:   r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] store_wstrb(input logic [1:0] st, input logic [1:0] off);
    logic [3:0] r;
    case (st)
      2'b00:   r = 4'b0001 << off;
      2'b01:   r = 4'b0011 << off;
      2'b10:   r = 4'b1111;
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] ld, input logic [31:0] word,
                                              input logic [1:0] off);
    logic [31:0] lane;
    logic [31:0] r;
    lane = word >> {off, 3'b000};
    case (ld)
      3'b000:  r = {{24{lane[7]}}, lane[7:0]};
      3'b001:  r = {{16{lane[15]}}, lane[15:0]};
      3'b010:  r = word;
      3'b011:  r = {24'd0, lane[7:0]};
      3'b100:  r = {16'd0, lane[15:0]};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [8:0]  cnt_inc;
  logic        we_q, we_d;
  logic [2:0]  load_q, load_d;
  logic [1:0]  off_q, off_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        done_q, done_d;
  logic        fault_q, fault_d;

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    load_d      = load_q;
    off_d       = off_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    rdata_d     = rdata_q;
    done_d      = 1'b0;
    fault_d     = 1'b0;
    cnt_inc     = {1'b0, cnt_q} + 9'd1;
    case (state_q)
      S_IDLE: begin
        if (lsu_valid) begin
          we_d   = lsu_we;
          load_d = Load;
          off_d  = lsu_addr[1:0];
          if (access_ok(lsu_we, Store, Load, lsu_addr[1:0])) begin
            state_d    = S_REQ;
            cnt_d      = 8'd0;
            mem_req_d  = 1'b1;
            mem_we_d   = lsu_we;
            mem_addr_d = {lsu_addr[31:2], 2'b00};
            if (lsu_we) begin
              mem_wdata_d = store_wdata(Store, lsu_wdata);
              mem_wstrb_d = store_wstrb(Store, lsu_addr[1:0]);
            end else begin
              mem_wdata_d = 32'd0;
              mem_wstrb_d = 4'b0000;
            end
          end else begin
            state_d = S_FAULT;
            done_d  = 1'b1;
            fault_d = 1'b1;
            rdata_d = 32'd0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      // A handshake in the same cycle as the limit takes priority over the timeout
      S_REQ: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          if (we_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            rdata_d = 32'd0;
          end else begin
            state_d = S_RESP;
            cnt_d   = 8'd0;
          end
        end else if (cnt_inc == TO_LIMIT) begin
          state_d   = S_FAULT;
          mem_req_d = 1'b0;
          done_d    = 1'b1;
          fault_d   = 1'b1;
          rdata_d   = 32'd0;
        end else begin
          cnt_d = cnt_inc[7:0];
        end
      end
      S_RESP: begin
        if (mem_rvalid) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          rdata_d = load_extend(load_q, mem_rdata, off_q);
        end else if (cnt_inc == TO_LIMIT) begin
          state_d = S_FAULT;
          done_d  = 1'b1;
          fault_d = 1'b1;
          rdata_d = 32'd0;
        end else begin
          cnt_d = cnt_inc[7:0];
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      we_q        <= 1'b0;
      load_q      <= 3'd0;
      off_q       <= 2'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_wstrb_q <= 4'd0;
      rdata_q     <= 32'd0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      load_q      <= load_d;
      off_q       <= off_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
    end
  end

  assign lsu_rdata = rdata_q;
  assign lsu_done  = done_q;
  assign lsu_fault = fault_q;
  assign lsu_busy  = lsu_valid & ~done_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized accesses
// checked against a byte-level behavioural model of the access rules.
module tb_load_store_unit;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        lsu_valid, lsu_we;
  logic [1:0]  Store;
  logic [2:0]  Load;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic        lsu_done, lsu_fault, lsu_busy;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int checks = 0;
  int failures = 0;
  int gnt_hs = 0;

  int          obs_done_cyc, obs_req_cycles;
  logic        obs_fault, obs_we, obs_stable, obs_busy_ok, obs_gap_ok;
  logic [31:0] obs_rdata, obs_addr, obs_wdata;
  logic [3:0]  obs_wstrb;

  int          exp_done_cyc, exp_req_cycles;
  logic        exp_fault;
  logic [31:0] exp_rdata, exp_wdata;
  logic [3:0]  exp_wstrb;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .lsu_valid(lsu_valid), .lsu_we(lsu_we), .Store(Store),
    .Load(Load), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_rdata(lsu_rdata),
    .lsu_done(lsu_done), .lsu_fault(lsu_fault), .lsu_busy(lsu_busy), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Reference model: access size from the code, alignment by modulo, timing by phase counts.
  task automatic model_access(input logic we, input logic [1:0] st, input logic [2:0] ld,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rword, input int gw, input int rw);
    int sz, off;
    bit sgn, legal;
    logic [63:0] v;
    off = int'(addr % 32'd4);
    sz = 0;
    sgn = 1'b0;
    if (we) begin
      if (st == 2'd0) sz = 1; else if (st == 2'd1) sz = 2; else if (st == 2'd2) sz = 4;
    end else begin
      case (ld)
        3'd0: begin sz = 1; sgn = 1'b1; end
        3'd1: begin sz = 2; sgn = 1'b1; end
        3'd2: sz = 4;
        3'd3: sz = 1;
        3'd4: sz = 2;
        default: sz = 0;
      endcase
    end
    legal = (sz != 0);
    if (legal) legal = ((off % sz) == 0);
    exp_wstrb = 4'b0000;
    exp_wdata = 32'd0;
    for (int i = 0; i < 4; i++) begin
      if (legal && we && i >= off && i < off + sz) exp_wstrb[i] = 1'b1;
      if (legal && we) exp_wdata[8*i +: 8] = wdata[8*(i % sz) +: 8];
    end
    exp_rdata = 32'd0;
    exp_fault = 1'b0;
    if (!legal) begin
      exp_req_cycles = 0; exp_done_cyc = 1; exp_fault = 1'b1;
    end else if (gw >= TO) begin
      exp_req_cycles = TO; exp_done_cyc = TO + 1; exp_fault = 1'b1;
    end else if (we) begin
      exp_req_cycles = gw + 1; exp_done_cyc = gw + 2;
    end else if (rw >= TO) begin
      exp_req_cycles = gw + 1; exp_done_cyc = gw + 2 + TO; exp_fault = 1'b1;
    end else begin
      exp_req_cycles = gw + 1; exp_done_cyc = gw + 3 + rw;
      v = ({32'd0, rword} >> (8 * off)) & ((64'd1 << (8 * sz)) - 64'd1);
      if (sgn && v[8*sz-1]) v = v - (64'd1 << (8 * sz));
      exp_rdata = v[31:0];
    end
  endtask

  // Drives one access and acts as the memory; records what the DUT did (cycle 0 = acceptance).
  task automatic run_access(input logic we, input logic [1:0] st, input logic [2:0] ld,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rword, input int gw, input int rw,
                            input bit chained);
    int req_cnt, gnt_cyc;
    bit hit;
    if (chained) begin
      lsu_we = we; Store = st; Load = ld; lsu_addr = addr; lsu_wdata = wdata;
      @(posedge clk); #1;
      obs_gap_ok = (mem_req === 1'b0) && (lsu_done === 1'b0) && (lsu_busy === 1'b1);
    end else begin
      lsu_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
      @(posedge clk); #1;
      lsu_valid = 1'b1; lsu_we = we; Store = st; Load = ld; lsu_addr = addr; lsu_wdata = wdata;
      obs_gap_ok = 1'b1;
    end
    req_cnt = 0; gnt_cyc = 0;
    obs_done_cyc = -1; obs_fault = 1'b0; obs_rdata = 32'd0; obs_stable = 1'b1;
    obs_busy_ok = 1'b1; obs_addr = 32'd0; obs_wdata = 32'd0; obs_wstrb = 4'd0; obs_we = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (mem_req === 1'b1) begin
        req_cnt++;
        if (req_cnt == 1) begin
          obs_addr = mem_addr; obs_wdata = mem_wdata; obs_wstrb = mem_wstrb; obs_we = mem_we;
        end else if ({mem_addr, mem_wdata, mem_wstrb, mem_we} !== {obs_addr, obs_wdata, obs_wstrb, obs_we}) begin
          obs_stable = 1'b0;
        end
      end
      if (lsu_busy !== ~lsu_done) obs_busy_ok = 1'b0;
      if (lsu_done === 1'b1) begin
        obs_done_cyc = k; obs_fault = lsu_fault; obs_rdata = lsu_rdata;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        break;
      end
      mem_gnt = (mem_req === 1'b1) && (req_cnt == gw + 1);
      if (mem_gnt) begin gnt_cyc = k; gnt_hs++; end
      hit = !we && gnt_cyc > 0 && k == gnt_cyc + 1 + rw;
      mem_rvalid = hit ? 1'b1 : ((mem_req === 1'b1) ? 1'($urandom_range(0, 1)) : 1'b0);
      mem_rdata = hit ? rword : $urandom;
    end
    obs_req_cycles = req_cnt;
  endtask

  task automatic test_reset;
    reset = 1'b1; lsu_valid = 1'b0; lsu_we = 1'b0; Store = 2'd0; Load = 3'd0;
    lsu_addr = 32'd0; lsu_wdata = 32'd0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    #12;
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, lsu_rdata, lsu_done, lsu_fault, lsu_busy} !== 105'd0) begin
      failures++;
      $display("FAIL reset_outputs got req=%b addr=%h wdata=%h strb=%b rdata=%h done=%b fault=%b busy=%b required all 0",
               mem_req, mem_addr, mem_wdata, mem_wstrb, lsu_rdata, lsu_done, lsu_fault, lsu_busy);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_store_byte;
    run_access(1'b1, 2'b00, 3'd0, 32'h0000_1003, 32'h0000_00AB, 32'd0, 0, 0, 1'b0);
    checks++;
    if ({obs_addr, obs_wdata, obs_wstrb, obs_we} !== {32'h0000_1000, 32'hABAB_ABAB, 4'b1000, 1'b1}) begin
      failures++;
      $display("FAIL sb_bus got addr=%h wdata=%h strb=%b we=%b required 00001000 abababab 1000 1",
               obs_addr, obs_wdata, obs_wstrb, obs_we);
    end
    checks++;
    if (obs_done_cyc != 2 || obs_fault !== 1'b0 || obs_req_cycles != 1 || !obs_busy_ok) begin
      failures++;
      $display("FAIL sb_timing got done_cyc=%0d fault=%b req_cycles=%0d busy_ok=%b required 2 0 1 1",
               obs_done_cyc, obs_fault, obs_req_cycles, obs_busy_ok);
    end
  endtask

  task automatic test_load_half;
    run_access(1'b0, 2'b00, 3'b001, 32'h0000_2002, 32'd0, 32'h8001_1234, 0, 0, 1'b0);
    checks++;
    if (obs_rdata !== 32'hFFFF_8001 || obs_done_cyc != 3 || obs_wstrb !== 4'b0000 || obs_we !== 1'b0) begin
      failures++;
      $display("FAIL lh got rdata=%h done_cyc=%0d strb=%b we=%b required ffff8001 3 0000 0",
               obs_rdata, obs_done_cyc, obs_wstrb, obs_we);
    end
    run_access(1'b0, 2'b00, 3'b100, 32'h0000_2002, 32'd0, 32'h8001_1234, 0, 0, 1'b0);
    checks++;
    if (obs_rdata !== 32'h0000_8001 || obs_done_cyc != 3 || obs_fault !== 1'b0 || obs_addr !== 32'h0000_2000) begin
      failures++;
      $display("FAIL lhu got rdata=%h done_cyc=%0d fault=%b addr=%h required 00008001 3 0 00002000",
               obs_rdata, obs_done_cyc, obs_fault, obs_addr);
    end
  endtask

  task automatic test_misalign;
    run_access(1'b0, 2'b00, 3'b010, 32'h0000_2001, 32'd0, 32'hDEAD_BEEF, 0, 0, 1'b0);
    checks++;
    if (obs_done_cyc != 1 || obs_fault !== 1'b1 || obs_req_cycles != 0 || obs_rdata !== 32'd0 || !obs_busy_ok) begin
      failures++;
      $display("FAIL lw_misalign got done_cyc=%0d fault=%b req_cycles=%0d rdata=%h busy_ok=%b required 1 1 0 0 1",
               obs_done_cyc, obs_fault, obs_req_cycles, obs_rdata, obs_busy_ok);
    end
    run_access(1'b1, 2'b11, 3'd0, 32'h0000_2000, 32'h1234_5678, 32'd0, 0, 0, 1'b0);
    checks++;
    if (obs_done_cyc != 1 || obs_fault !== 1'b1 || obs_req_cycles != 0) begin
      failures++;
      $display("FAIL illegal_store got done_cyc=%0d fault=%b req_cycles=%0d required 1 1 0",
               obs_done_cyc, obs_fault, obs_req_cycles);
    end
  endtask

  task automatic test_timeout;
    run_access(1'b1, 2'b10, 3'd0, 32'h0000_4000, 32'hCAFE_F00D, 32'd0, 99, 0, 1'b0);
    checks++;
    if (obs_req_cycles != 4 || obs_done_cyc != 5 || obs_fault !== 1'b1) begin
      failures++;
      $display("FAIL timeout_abort got req_cycles=%0d done_cyc=%0d fault=%b required 4 5 1",
               obs_req_cycles, obs_done_cyc, obs_fault);
    end
    run_access(1'b1, 2'b10, 3'd0, 32'h0000_4000, 32'hCAFE_F00D, 32'd0, 3, 0, 1'b0);
    checks++;
    if (obs_req_cycles != 4 || obs_done_cyc != 5 || obs_fault !== 1'b0 || !obs_stable) begin
      failures++;
      $display("FAIL timeout_gnt_wins got req_cycles=%0d done_cyc=%0d fault=%b stable=%b required 4 5 0 1",
               obs_req_cycles, obs_done_cyc, obs_fault, obs_stable);
    end
  endtask

  task automatic test_back_to_back;
    int hs0;
    hs0 = gnt_hs;
    run_access(1'b1, 2'b10, 3'd0, 32'h0000_5000, 32'h1122_3344, 32'd0, 0, 0, 1'b0);
    run_access(1'b1, 2'b10, 3'd0, 32'h0000_5004, 32'h5566_7788, 32'd0, 0, 0, 1'b1);
    checks++;
    if (!obs_gap_ok || obs_req_cycles != 1 || obs_done_cyc != 2 || obs_addr !== 32'h0000_5004 ||
        obs_wdata !== 32'h5566_7788) begin
      failures++;
      $display("FAIL b2b_second got gap_ok=%b req_cycles=%0d done_cyc=%0d addr=%h wdata=%h required 1 1 2 00005004 55667788",
               obs_gap_ok, obs_req_cycles, obs_done_cyc, obs_addr, obs_wdata);
    end
    checks++;
    if (gnt_hs - hs0 != 2) begin
      failures++;
      $display("FAIL b2b_handshakes got %0d required 2", gnt_hs - hs0);
    end
  endtask

  task automatic test_random;
    logic        we;
    logic [1:0]  st;
    logic [2:0]  ld;
    logic [31:0] addr, wdata, rword;
    int          gw, rw;
    for (int n = 0; n < 80; n++) begin
      we = 1'($urandom_range(0, 1));
      st = 2'($urandom_range(0, 3));
      ld = 3'($urandom_range(0, 5));
      addr = $urandom; wdata = $urandom; rword = $urandom;
      gw = $urandom_range(0, 5);
      rw = $urandom_range(0, 5);
      model_access(we, st, ld, addr, wdata, rword, gw, rw);
      run_access(we, st, ld, addr, wdata, rword, gw, rw, 1'b0);
      checks++;
      if (obs_done_cyc != exp_done_cyc || obs_fault !== exp_fault || obs_req_cycles != exp_req_cycles) begin
        failures++;
        $display("FAIL rnd_timing n=%0d got done=%0d fault=%b req=%0d required %0d %b %0d",
                 n, obs_done_cyc, obs_fault, obs_req_cycles, exp_done_cyc, exp_fault, exp_req_cycles);
      end
      if (exp_req_cycles > 0) begin
        checks++;
        if (obs_addr !== {addr[31:2], 2'b00} || obs_we !== we || obs_wstrb !== exp_wstrb ||
            (we && obs_wdata !== exp_wdata) || !obs_stable) begin
          failures++;
          $display("FAIL rnd_bus n=%0d got addr=%h we=%b strb=%b wdata=%h stable=%b required %h %b %b %h 1",
                   n, obs_addr, obs_we, obs_wstrb, obs_wdata, obs_stable,
                   {addr[31:2], 2'b00}, we, exp_wstrb, exp_wdata);
        end
      end
      if (!we || exp_fault) begin
        checks++;
        if (obs_rdata !== exp_rdata) begin
          failures++;
          $display("FAIL rnd_rdata n=%0d got %h required %h", n, obs_rdata, exp_rdata);
        end
      end
      checks++;
      if (!obs_busy_ok) begin
        failures++;
        $display("FAIL rnd_busy n=%0d got busy not equal to valid and not done, required equal", n);
      end
    end
  endtask

  task automatic test_reset_in_resp;
    int late_done, late_req;
    lsu_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(posedge clk); #1;
    lsu_valid = 1'b1; lsu_we = 1'b0; Load = 3'b010; Store = 2'd0; lsu_addr = 32'h0000_3000;
    @(posedge clk); #1;
    mem_gnt = mem_req;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, lsu_rdata, lsu_done, lsu_fault} !== 104'd0) begin
      failures++;
      $display("FAIL reset_in_resp got req=%b addr=%h rdata=%h done=%b fault=%b required all 0",
               mem_req, mem_addr, lsu_rdata, lsu_done, lsu_fault);
    end
    @(posedge clk); #1;
    reset = 1'b0; lsu_valid = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    late_done = 0; late_req = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      if (lsu_done !== 1'b0) late_done++;
      if (mem_req !== 1'b0) late_req++;
    end
    checks++;
    if (late_done != 0 || late_req != 0) begin
      failures++;
      $display("FAIL late_rvalid got done_cycles=%0d req_cycles=%0d required 0 0", late_done, late_req);
    end
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_load_half();
    test_misalign();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_in_resp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Multi-cycle data-memory responder for the RISC-V core. It executes the memory operations the controller requests (MemWrite with a Store code, or a Load code) against a word-wide handshaked data memory. It handles byte-lane steering, write strobes, sign/zero extension, misalignment, and bus timeout. It raises lsu_busy so the core stalls until the access completes.

Parameters:
TIMEOUT_CYCLES, 255, cycles to wait in REQ or RESP before aborting with fault (1..255)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
lsu_valid  in  1  core requests an access; held until lsu_done
lsu_we  in  1  1=store (controller MemWrite), 0=load
Store  in  2  00=byte, 01=half, 10=word, 11=illegal
Load  in  3  000=lb, 001=lh, 010=lw, 011=lbu, 100=lhu, others illegal
lsu_addr  in  32  byte address
lsu_wdata  in  32  store data, right-justified
lsu_rdata  out  32  extended load result; valid while lsu_done=1
lsu_done  out  1  one-cycle completion pulse (success or fault)
lsu_fault  out  1  one-cycle pulse with lsu_done on misalign, illegal code or timeout
lsu_busy  out  1  stall: lsu_valid & ~lsu_done
mem_req  out  1  memory request, held until mem_gnt
mem_we  out  1  write enable
mem_addr  out  32  word address: {addr[31:2],2'b00}
mem_wdata  out  32  lane-replicated store data
mem_wstrb  out  4  byte strobes (0000 for loads)
mem_gnt  in  1  memory accepts the request this cycle
mem_rvalid  in  1  load data valid
mem_rdata  in  32  load data word

Behaviour:
- Reset (asynchronous): state=IDLE, timeout counter=0, all outputs 0 (mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, lsu_rdata, lsu_done, lsu_fault). An in-flight access is abandoned.
- States: IDLE, REQ, RESP, DONE, FAULT.
- IDLE: on lsu_valid, capture we, code, addr and wdata.
  - Illegal code, or misalignment (half with addr[0]=1; word with addr[1:0]!=0), goes to FAULT. No mem_req is issued.
  - Otherwise go to REQ.
- REQ: mem_req=1 with registered mem_we, mem_addr, mem_wdata and mem_wstrb, all stable until mem_gnt.
  - On mem_gnt: a store goes to DONE; a load goes to RESP.
  - mem_rvalid in REQ is ignored.
- RESP: wait for mem_rvalid. Then lsu_rdata <= extended lane and go to DONE.
- DONE: lsu_done=1 for one cycle, then IDLE. lsu_valid is not sampled in DONE; the next request is accepted in IDLE at the earliest one cycle later.
- FAULT: lsu_done=1 and lsu_fault=1 for one cycle, lsu_rdata=0, then IDLE.
- Timeout: the counter clears on entry to REQ or RESP and increments each cycle in those states. If it reaches TIMEOUT_CYCLES with no mem_gnt/mem_rvalid, go to FAULT and drop mem_req. A handshake arriving in the same cycle as the limit wins.
- Store steering, with off = addr[1:0]:
  - byte: wdata = {4{wdata[7:0]}}, wstrb = 0001 << off
  - half: wdata = {2{wdata[15:0]}}, wstrb = 0011 << off
  - word: wdata unchanged, wstrb = 1111
- Load extraction: lane = mem_rdata >> (8*off).
  - lb/lh sign-extend bit 7/15 of the lane.
  - lbu/lhu zero-extend.
  - lw passes the word through.
- Latency when gnt and rvalid arrive the cycle after they are first possible:
  - store: done 2 cycles after acceptance
  - load: done 3 cycles after acceptance
  - fault: done 1 cycle after acceptance
- lsu_busy is combinational.
- mem_req deasserts in the cycle after mem_gnt is seen, so a request is never issued twice.

Test Plan:
- sb: addr=0x1003, wdata=0x000000AB, gnt immediate -> mem_addr=0x1000, wdata=0xABABABAB, wstrb=1000, we=1; done 2 cycles after acceptance, fault=0.
- lh then lhu: addr=0x2002, mem_rdata=0x80011234 -> lsu_rdata=0xFFFF8001 (lh) and 0x00008001 (lhu); wstrb=0000.
- lw: addr=0x2001 -> FAULT; done=fault=1 next cycle; mem_req never asserts; busy drops with done.
- Timeout with TIMEOUT_CYCLES=4: sw, mem_gnt held 0 -> mem_req high 4 cycles, then fault pulse and mem_req=0. Repeat with gnt on the 4th cycle -> normal completion.
- Back-to-back: lsu_valid held, two consecutive sw -> second mem_req asserts only after IDLE; exactly two gnt handshakes.
- Reset during RESP -> all outputs 0 immediately. A late mem_rvalid after reset is ignored; no done pulse.
